// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N producers, the arbiter and one consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface rr_mux_arbiter_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Registered N-to-1 selector with round-robin / fixed-priority arbitration.
// One output register stage; the round-robin pointer advances only on accepted grants.
module rr_mux_arbiter #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_arbiter_if.slave    bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] data_reg,  data_next;
    logic [SEL_W-1:0] sel_reg,   sel_next;
    logic [SEL_W-1:0] ptr_reg,   ptr_next;

    logic             load;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] data_ch [CHANNELS];
    logic [CHANNELS-1:0] ready_vec;

    assign load = !valid_reg || bus.out_ready;

    // Search from the base index (ptr in round-robin, 0 in fixed priority);
    // iterating downward lets the nearest requester overwrite farther ones.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = (bus.mode ? 0 : int'(ptr_reg)) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (bus.in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign data_ch[gi]   = bus.in_data[gi*WIDTH +: WIDTH];
            assign ready_vec[gi] = !rst && load && grant_found && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    assign bus.in_ready = ready_vec;

    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        if (load && grant_found) begin
            valid_next = 1'b1;
            data_next  = data_ch[grant_idx];
            sel_next   = grant_idx;
            if (!bus.mode) begin
                ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (load) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.out_data  = data_reg;
    assign bus.out_sel   = sel_reg;
endmodule
